// File: rtl/spi_pkg.sv
// spi_pkg
// Shared types and constants for the SPI register-bank slice.
//   spi_byte_t        : one 8-bit SPI word
//   spi_bank_state_t  : write-commit FSM states (IDLE, CAPTURE, COMMIT)
//   STATUS_*_BIT      : bit positions inside the read-only status byte
//   DEFAULT_STATUS_ADDR : default address of the status register
//   spi_pack_status() : assembles the status byte from its fields
package spi_pkg;

    typedef logic [7:0] spi_byte_t;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        COMMIT
    } spi_bank_state_t;

    localparam int STATUS_ADDR_ERR_BIT = 0;
    localparam int STATUS_OVERRUN_BIT  = 1;
    localparam int STATUS_ERR_CNT_LSB  = 4;

    localparam spi_byte_t DEFAULT_STATUS_ADDR = 8'hFF;

    // Status byte layout: {err_cnt[3:0], 2'b00, overrun, addr_err}
    function automatic spi_byte_t spi_pack_status(input logic [3:0] err_nibble,
                                                  input logic       overrun,
                                                  input logic       addr_err);
        spi_byte_t s;
        s = '0;
        s[STATUS_ERR_CNT_LSB +: 4]  = err_nibble;
        s[STATUS_OVERRUN_BIT]       = overrun;
        s[STATUS_ADDR_ERR_BIT]      = addr_err;
        return s;
    endfunction

endpackage

// File: rtl/spi_toggle_sync.sv
// spi_toggle_sync
// Brings a toggle-style handshake from a foreign clock domain into iclk and
// turns every change of the toggle into a one-cycle edge pulse. Usable for
// both the PICO write handoff and POCI-side handshakes.
// Ports:
//   iclk_i    : destination clock
//   rstn_i    : synchronous active-low reset
//   toggle_i  : asynchronous toggle, inverts once per handshake
//   edge_o    : one-cycle pulse per observed toggle change (masked until armed)
module spi_toggle_sync (
    input  logic iclk_i,
    input  logic rstn_i,
    input  logic toggle_i,
    output logic edge_o
);

    logic       s1_q, s2_q, s3_q;
    logic       armed_q;
    logic [1:0] arm_cnt_q;

    // Three-flop chain: s1/s2 resolve metastability, s3 holds the previous
    // settled value so s2^s3 marks a change. The arming counter keeps the
    // edge masked until the chain has flushed the toggle level present at
    // reset release, so a toggle idling high never looks like a new word.
    always_ff @(posedge iclk_i) begin
        if (!rstn_i) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            armed_q   <= 1'b0;
            arm_cnt_q <= 2'd0;
        end else begin
            s1_q <= toggle_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
            if (!armed_q) begin
                if (arm_cnt_q == 2'd2) begin
                    armed_q <= 1'b1;
                end else begin
                    arm_cnt_q <= arm_cnt_q + 2'd1;
                end
            end
        end
    end

    assign edge_o = armed_q & (s2_q ^ s3_q);

endmodule

// File: rtl/spi_reg_bank.sv
// spi_reg_bank
// Commits 8-bit words handed over from the SPI PICO stage (sclk domain) into
// a bank of configuration registers clocked by iclk, drives them in parallel
// to the core, and serves registered read data to the POCI stage.
// Optional feature macro: SPI_WR_ERR_CNT_EN adds a saturating 4-bit count of
// dropped writes, reported in status[7:4].
// Ports:
//   iclk, rstn        : clock and synchronous active-low reset
//   wr_toggle         : PICO handshake toggle (sclk domain)
//   wr_addr, wr_data  : PICO word, stable from toggle until the next word
//   rd_addr, rd_data  : read port, one cycle latency
//   reg_flat          : register i on [8i+7:8i]
//   commit_pulse      : one-cycle pulse per committed register write
//   addr_err          : sticky flag, a write hit an unmapped address
module spi_reg_bank
    import spi_pkg::*;
#(
    parameter int        NUM_REGS    = 16,
    parameter spi_byte_t RESET_VAL   = 8'h00,
    parameter spi_byte_t STATUS_ADDR = DEFAULT_STATUS_ADDR
) (
    input  logic                  iclk,
    input  logic                  rstn,
    input  logic                  wr_toggle,
    input  logic [7:0]            wr_addr,
    input  logic [7:0]            wr_data,
    input  logic [7:0]            rd_addr,
    output logic [7:0]            rd_data,
    output logic [NUM_REGS*8-1:0] reg_flat,
    output logic                  commit_pulse,
    output logic                  addr_err
);

    localparam int         IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);

    spi_bank_state_t state_q, state_d;
    logic            pending_q, pending_d;
    logic            overrun_q, overrun_d;
    logic            addr_err_q, addr_err_d;
    logic            commit_q, commit_d;
    spi_byte_t       hold_addr_q, hold_addr_d;
    spi_byte_t       hold_data_q, hold_data_d;
    spi_byte_t       regs_q [NUM_REGS];
    spi_byte_t       regs_d [NUM_REGS];
    spi_byte_t       rd_data_q, rd_data_d;
    logic [3:0]      err_nibble;
    logic            wr_edge;

`ifdef SPI_WR_ERR_CNT_EN
    logic [3:0] err_cnt_q, err_cnt_d;
    assign err_nibble = err_cnt_q;
`else
    assign err_nibble = 4'h0;
`endif

    spi_toggle_sync u_wr_sync (
        .iclk_i   (iclk),
        .rstn_i   (rstn),
        .toggle_i (wr_toggle),
        .edge_o   (wr_edge)
    );

    // Commit FSM. An edge that arrives while busy is remembered in pending;
    // a second one before service flags overrun. Because the PICO bus only
    // carries the latest word, servicing pending naturally commits the
    // newest word and the intermediate one is lost.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        overrun_d   = overrun_q;
        addr_err_d  = addr_err_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        commit_d    = 1'b0;
        regs_d      = regs_q;
`ifdef SPI_WR_ERR_CNT_EN
        err_cnt_d   = err_cnt_q;
`endif

        if (wr_edge && pending_q) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (wr_edge || pending_q) begin
                    hold_addr_d = wr_addr;
                    hold_data_d = wr_data;
                    pending_d   = 1'b0;
                    state_d     = CAPTURE;
                end
            end
            CAPTURE: begin
                if ({1'b0, hold_addr_q} < NUM_REGS_W) begin
                    regs_d[hold_addr_q[IDX_W-1:0]] = hold_data_q;
                    commit_d = 1'b1;
                end else begin
                    addr_err_d = 1'b1;
`ifdef SPI_WR_ERR_CNT_EN
                    if (err_cnt_q != 4'hF) begin
                        err_cnt_d = err_cnt_q + 4'd1;
                    end
`endif
                end
                if (wr_edge) begin
                    pending_d = 1'b1;
                end
                state_d = COMMIT;
            end
            COMMIT: begin
                if (wr_edge) begin
                    pending_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read mux samples the registers before this cycle's commit, so a read
    // colliding with a write returns the old value for one cycle.
    always_comb begin
        rd_data_d = 8'h00;
        if ({1'b0, rd_addr} < NUM_REGS_W) begin
            rd_data_d = regs_q[rd_addr[IDX_W-1:0]];
        end else if (rd_addr == STATUS_ADDR) begin
            rd_data_d = spi_pack_status(err_nibble, overrun_q, addr_err_q);
        end
    end

    always_ff @(posedge iclk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            overrun_q   <= 1'b0;
            addr_err_q  <= 1'b0;
            commit_q    <= 1'b0;
            hold_addr_q <= 8'h00;
            hold_data_q <= 8'h00;
            rd_data_q   <= 8'h00;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
`ifdef SPI_WR_ERR_CNT_EN
            err_cnt_q   <= 4'h0;
`endif
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            addr_err_q  <= addr_err_d;
            commit_q    <= commit_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            rd_data_q   <= rd_data_d;
            regs_q      <= regs_d;
`ifdef SPI_WR_ERR_CNT_EN
            err_cnt_q   <= err_cnt_d;
`endif
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_flat[8*g +: 8] = regs_q[g];
    end

    assign rd_data      = rd_data_q;
    assign commit_pulse = commit_q;
    assign addr_err     = addr_err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank
// Self-checking bench for spi_reg_bank: directed handshake scenarios plus
// randomized isolated writes, compared against a register-array model.
module tb_spi_reg_bank;

    localparam int         NUM_REGS = 16;
    localparam int         FLAT_W   = NUM_REGS * 8;
    localparam logic [7:0] RST_VAL  = 8'h3C;

    logic              iclk = 1'b0;
    logic              rstn;
    logic              wr_toggle;
    logic [7:0]        wr_addr;
    logic [7:0]        wr_data;
    logic [7:0]        rd_addr;
    logic [7:0]        rd_data;
    logic [FLAT_W-1:0] reg_flat;
    logic              commit_pulse;
    logic              addr_err;

    int checkCount  = 0;
    int errorCount  = 0;
    int pulseCount  = 0;

    logic [7:0] modelRegs [NUM_REGS];
    logic       modelAddrErr;
    logic       modelOverrun;
    int         modelErrCnt;

    spi_reg_bank #(
        .NUM_REGS    (NUM_REGS),
        .RESET_VAL   (RST_VAL),
        .STATUS_ADDR (8'hFF)
    ) dut (
        .iclk         (iclk),
        .rstn         (rstn),
        .wr_toggle    (wr_toggle),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .reg_flat     (reg_flat),
        .commit_pulse (commit_pulse),
        .addr_err     (addr_err)
    );

    always #5 iclk = ~iclk;

    // Count commit pulses away from the active edge
    always @(negedge iclk) begin
        if (commit_pulse === 1'b1) pulseCount++;
    end

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge iclk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] data);
        wr_addr   = addr;
        wr_data   = data;
        wr_toggle = ~wr_toggle;
    endtask

    task automatic modelReset();
        for (int i = 0; i < NUM_REGS; i++) modelRegs[i] = RST_VAL;
        modelAddrErr = 1'b0;
        modelOverrun = 1'b0;
        modelErrCnt  = 0;
    endtask

    task automatic modelWrite(input logic [7:0] addr, input logic [7:0] data);
        if (int'(addr) < NUM_REGS) begin
            modelRegs[int'(addr)] = data;
        end else begin
            modelAddrErr = 1'b1;
            if (modelErrCnt < 15) modelErrCnt++;
        end
    endtask

    function automatic logic [7:0] modelRead(input logic [7:0] addr);
        logic [3:0] nib;
`ifdef SPI_WR_ERR_CNT_EN
        nib = 4'(modelErrCnt);
`else
        nib = 4'h0;
`endif
        if (int'(addr) < NUM_REGS) return modelRegs[int'(addr)];
        if (addr == 8'hFF) return {nib, 2'b00, modelOverrun, modelAddrErr};
        return 8'h00;
    endfunction

    function automatic logic [FLAT_W-1:0] modelFlat();
        logic [FLAT_W-1:0] f;
        for (int i = 0; i < NUM_REGS; i++) f[i*8 +: 8] = modelRegs[i];
        return f;
    endfunction

    task automatic readCheck(input string tag, input logic [7:0] addr);
        rd_addr = addr;
        step();
        checkOutput(tag, rd_data, modelRead(addr));
    endtask

    // One isolated write: latency, pulse width, collision read, final state
    task automatic writeAndCheck(input logic [7:0] addr, input logic [7:0] data);
        logic [7:0] oldVal;
        logic [7:0] newVal;
        int         firstSeen;
        int         startPulses;
        bit         valid;
        valid       = (int'(addr) < NUM_REGS);
        oldVal      = modelRead(addr);
        modelWrite(addr, data);
        newVal      = modelRead(addr);
        startPulses = pulseCount;
        firstSeen   = 0;
        rd_addr     = addr;
        applyStimulus(addr, data);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            step();
            if (commit_pulse === 1'b1 && firstSeen == 0) firstSeen = cyc;
            if (cyc == 4) checkOutput("collide_old", rd_data, oldVal);
            if (cyc == 5) checkOutput("collide_new", rd_data, newVal);
        end
        checkOutput("latency", firstSeen, valid ? 4 : 0);
        checkOutput("pulse_count", pulseCount - startPulses, valid ? 1 : 0);
        checkOutput("reg_flat", reg_flat, modelFlat());
        checkOutput("addr_err", addr_err, modelAddrErr);
    endtask

    initial begin
        int         startPulses;
        logic [7:0] a;
        logic [7:0] d;
        int         r;

        rstn      = 1'b0;
        wr_toggle = 1'b1;
        wr_addr   = 8'h00;
        wr_data   = 8'h00;
        rd_addr   = 8'h00;
        modelReset();

        // Reset with toggle idling high must not produce a write
        step();
        step();
        checkOutput("rst_rd_data", rd_data, 8'h00);
        checkOutput("rst_commit", commit_pulse, 1'b0);
        checkOutput("rst_addr_err", addr_err, 1'b0);
        checkOutput("rst_flat", reg_flat, modelFlat());
        rstn        = 1'b1;
        startPulses = pulseCount;
        for (int i = 0; i < 10; i++) step();
        checkOutput("no_spurious", pulseCount - startPulses, 0);
        checkOutput("flat_after_rel", reg_flat, modelFlat());
        readCheck("status_clean", 8'hFF);

        // Directed writes
        writeAndCheck(8'h03, 8'hA5);
        checkOutput("reg3_byte", reg_flat[31:24], 8'hA5);
        readCheck("read_reg3", 8'h03);
        writeAndCheck(8'h20, 8'h11);
        readCheck("status_err", 8'hFF);
        writeAndCheck(8'hFF, 8'h77);
        readCheck("unmapped_read", 8'h40);

        // Randomized isolated writes and reads
        for (int n = 0; n < 30; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)       a = 8'($urandom_range(0, NUM_REGS - 1));
            else if (r == 7) a = 8'hFF;
            else             a = 8'($urandom_range(NUM_REGS, 254));
            d = 8'($urandom);
            writeAndCheck(a, d);
            readCheck("rand_read", 8'($urandom_range(0, 255)));
        end
        readCheck("status_rand", 8'hFF);

        // Pending path: second toggle lands while the first is being committed.
        // The bus switches to word 2 only after word 1 has been captured.
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
        modelReset();
        for (int i = 0; i < 5; i++) step();
        startPulses = pulseCount;
        applyStimulus(8'h01, 8'h0F);
        step();
        step();
        wr_toggle = ~wr_toggle;
        step();
        wr_addr = 8'h02;
        wr_data = 8'hF0;
        for (int i = 0; i < 10; i++) step();
        modelWrite(8'h01, 8'h0F);
        modelWrite(8'h02, 8'hF0);
        checkOutput("pend_pulses", pulseCount - startPulses, 2);
        checkOutput("pend_flat", reg_flat, modelFlat());
        readCheck("pend_status", 8'hFF);

        // Overrun: three toggles on consecutive cycles; middle word is lost
        startPulses = pulseCount;
        applyStimulus(8'h04, 8'h44);
        step();
        wr_toggle = ~wr_toggle;
        step();
        wr_toggle = ~wr_toggle;
        step();
        wr_addr = 8'h06;
        wr_data = 8'h66;
        for (int i = 0; i < 10; i++) step();
        modelWrite(8'h04, 8'h44);
        modelWrite(8'h06, 8'h66);
        modelOverrun = 1'b1;
        checkOutput("ovr_pulses", pulseCount - startPulses, 2);
        checkOutput("ovr_flat", reg_flat, modelFlat());
        readCheck("ovr_status", 8'hFF);
        readCheck("ovr_newest", 8'h06);

        // Reset while the FSM is in CAPTURE discards the transaction
        writeAndCheck(8'h30, 8'h01);
        startPulses = pulseCount;
        applyStimulus(8'h07, 8'h99);
        step();
        step();
        step();
        rstn = 1'b0;
        step();
        step();
        modelReset();
        checkOutput("midrst_flat", reg_flat, modelFlat());
        checkOutput("midrst_addr_err", addr_err, 1'b0);
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) step();
        checkOutput("midrst_pulses", pulseCount - startPulses, 0);
        checkOutput("midrst_flat2", reg_flat, modelFlat());
        writeAndCheck(8'h07, 8'h42);
        readCheck("final_status", 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
